// File: rtl/shftreg_rx.sv
// shftreg_rx: framed serial receiver paired with the shift register transmitter.
//
// Line format: idle high, start bit 0, WIDTH data bits, optional even-parity
// bit, stop bit 1. Each bit is CLKS_PER_BIT clocks long and is sampled at its
// centre. RL, captured when the start edge is seen, selects the bit order:
// 1 = LSB first, 0 = MSB first.
//
// Optional feature: define SHFTREG_RX_PARITY_EN to add a parity bit after
// the data bits and the ParErr output.
module shftreg_rx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic             CLK,
    input  logic             Clear,
    input  logic             InS,
    input  logic             RL,
    output logic [WIDTH-1:0] D,
    output logic             Valid,
    output logic             FrameErr,
`ifdef SHFTREG_RX_PARITY_EN
    output logic             ParErr,
`endif
    output logic             Busy
);

    // Offset from the start-detect edge to the centre of the start bit.
    localparam int HALF = CLKS_PER_BIT / 2;

    // Counter widths. A one-bit minimum keeps degenerate sizes legal.
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_MID  = CW'(HALF - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef SHFTREG_RX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0]    cnt;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_next;
    logic             rl_q;
    logic             cnt_done;
    logic             mid_hit;
    logic             last_bit;
    logic             valid_nxt;
    logic             ferr_nxt;
`ifdef SHFTREG_RX_PARITY_EN
    logic             par_q;
    logic             par_ok;
    logic             perr_nxt;
`endif

    // Decode the bit-timing counter and bit index into sample strobes.
    always_comb begin
        cnt_done = (cnt == CNT_LAST);
        mid_hit  = (cnt == CNT_MID);
        last_bit = (idx == IDX_LAST);
    end

    // Next value of the assembly register for the captured bit order.
    always_comb begin
        shift_next = shreg;
        if (rl_q) begin
            shift_next = WIDTH'({InS, shreg} >> 1);
        end else begin
            shift_next = WIDTH'({shreg, InS});
        end
    end

`ifdef SHFTREG_RX_PARITY_EN
    // Even parity: the received parity bit must equal the XOR of the data.
    always_comb begin
        par_ok = (par_q == ^shreg);
    end
`endif

    // State register.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: walk start, data, (parity,) stop at bit centres.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!InS) begin
                    next_state = START;
                end
            end
            START: begin
                if (mid_hit) begin
                    next_state = InS ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_done && last_bit) begin
`ifdef SHFTREG_RX_PARITY_EN
                    next_state = PARITY;
`else
                    next_state = STOP;
`endif
                end
            end
`ifdef SHFTREG_RX_PARITY_EN
            PARITY: begin
                if (cnt_done) begin
                    next_state = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_done) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode: busy flag and the result strobes due at the stop sample.
    always_comb begin
        Busy      = (state != IDLE);
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
`ifdef SHFTREG_RX_PARITY_EN
        perr_nxt  = 1'b0;
`endif
        if (state == STOP && cnt_done) begin
            if (!InS) begin
                ferr_nxt = 1'b1;
`ifdef SHFTREG_RX_PARITY_EN
            end else if (!par_ok) begin
                perr_nxt = 1'b1;
`endif
            end else begin
                valid_nxt = 1'b1;
            end
        end
    end

    // Datapath: bit timing, bit capture, and registered result outputs.
    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            cnt      <= '0;
            idx      <= '0;
            shreg    <= '0;
            rl_q     <= 1'b0;
            D        <= '0;
            Valid    <= 1'b0;
            FrameErr <= 1'b0;
`ifdef SHFTREG_RX_PARITY_EN
            ParErr   <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            Valid    <= valid_nxt;
            FrameErr <= ferr_nxt;
`ifdef SHFTREG_RX_PARITY_EN
            ParErr   <= perr_nxt;
`endif
            if (valid_nxt) begin
                D <= shreg;
            end
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!InS) begin
                        rl_q <= RL;
                    end
                end
                START: begin
                    if (mid_hit) begin
                        cnt <= '0;
                        idx <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        shreg <= shift_next;
                        idx   <= last_bit ? '0 : idx + IW'(1);
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef SHFTREG_RX_PARITY_EN
                PARITY: begin
                    if (cnt_done) begin
                        cnt   <= '0;
                        par_q <= InS;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt_done) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt <= '0;
                    idx <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shftreg_rx.sv
// tb_shftreg_rx: scoreboard bench for shftreg_rx. Frames are described as a
// list of transmitted bits; the expected word, strobe kind and strobe time
// come from the frame description, and a monitor compares each strobe.
module tb_shftreg_rx;

    localparam int WIDTH = 4;
    localparam int CPB   = 4;
    localparam int HALF  = CPB / 2;
`ifdef SHFTREG_RX_PARITY_EN
    localparam int NBITS = WIDTH + 2;
`else
    localparam int NBITS = WIDTH + 1;
`endif

    localparam int K_VALID = 0;
    localparam int K_FERR  = 1;
    localparam int K_PERR  = 2;

    typedef struct {
        int               kind;
        logic [WIDTH-1:0] d;
        longint           cyc;
    } exp_t;

    typedef struct {
        logic [WIDTH-1:0] bits;
        logic             rl;
        logic             par;
        logic             stop;
        logic             toggle;
    } frame_t;

    logic             CLK;
    logic             Clear;
    logic             InS;
    logic             RL;
    logic [WIDTH-1:0] D;
    logic             Valid;
    logic             FrameErr;
    logic             ParErr;
    logic             Busy;

    int               checks   = 0;
    int               failures = 0;
    longint           cyc      = 0;
    logic [WIDTH-1:0] last_good;
    exp_t             sb[$];
    exp_t             mon_e;
    int               got_kind;

    shftreg_rx #(
        .WIDTH       (WIDTH),
        .CLKS_PER_BIT(CPB)
    ) dut (
        .CLK     (CLK),
        .Clear   (Clear),
        .InS     (InS),
        .RL      (RL),
        .D       (D),
        .Valid   (Valid),
        .FrameErr(FrameErr),
`ifdef SHFTREG_RX_PARITY_EN
        .ParErr  (ParErr),
`endif
        .Busy    (Busy)
    );

`ifndef SHFTREG_RX_PARITY_EN
    assign ParErr = 1'b0;
`endif

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check_output(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic drive_bit(input logic b, input logic toggle);
        InS = b;
        repeat (CPB) begin
            @(posedge CLK);
            #1;
            if (toggle) RL = 1'($urandom_range(0, 1));
        end
    endtask

    // Build the expectation from the frame description, then send it.
    task automatic apply_frame(input frame_t f);
        exp_t             e;
        logic [WIDTH-1:0] word;
        logic             par_ok;
        for (int i = 0; i < WIDTH; i++) begin
            word[i] = f.rl ? f.bits[i] : f.bits[WIDTH-1-i];
        end
`ifdef SHFTREG_RX_PARITY_EN
        par_ok = (f.par == ^f.bits);
`else
        par_ok = 1'b1;
`endif
        e.cyc = cyc + 1 + NBITS * CPB + HALF;
        if (!f.stop) begin
            e.kind = K_FERR;
            e.d    = last_good;
        end else if (!par_ok) begin
            e.kind = K_PERR;
            e.d    = last_good;
        end else begin
            e.kind    = K_VALID;
            e.d       = word;
            last_good = word;
        end
        sb.push_back(e);
        RL = f.rl;
        drive_bit(1'b0, f.toggle);
        for (int i = 0; i < WIDTH; i++) begin
            drive_bit(f.bits[i], f.toggle);
        end
`ifdef SHFTREG_RX_PARITY_EN
        drive_bit(f.par, f.toggle);
`endif
        drive_bit(f.stop, f.toggle);
        InS = 1'b1;
    endtask

    task automatic apply_glitch();
        int n;
        InS = 1'b0;
        step(1);
        check_output("glitch_busy_high", longint'(Busy), 1);
        InS = 1'b1;
        n = 0;
        while (Busy && n < HALF + 1) begin
            step(1);
            n++;
        end
        check_output("glitch_idle_return", longint'(Busy), 0);
        step(CPB);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 400) begin
            step(1);
            n++;
        end
        check_output("scoreboard_drained", longint'(sb.size()), 0);
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (!Clear && (Valid || FrameErr || ParErr)) begin
            check_output("strobe_exclusive", longint'(Valid) + longint'(FrameErr) + longint'(ParErr), 1);
            check_output("strobe_expected", longint'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e    = sb.pop_front();
                got_kind = Valid ? K_VALID : (FrameErr ? K_FERR : K_PERR);
                check_output("strobe_kind", longint'(got_kind), longint'(mon_e.kind));
                check_output("word_d", longint'(D), longint'(mon_e.d));
                check_output("strobe_cycle", cyc, mon_e.cyc);
                check_output("busy_at_strobe", longint'(Busy), 0);
            end
        end
    end

    initial begin
        #400000;
        failures++;
        checks++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        frame_t f;
        int     gap;
        last_good = '0;
        Clear     = 1'b1;
        RL        = 1'b0;
        InS       = 1'b0;

        // Reset with a toggling line.
        repeat (4) begin
            #5 InS = ~InS;
        end
        @(posedge CLK);
        #1;
        check_output("reset_d", longint'(D), 0);
        check_output("reset_valid", longint'(Valid), 0);
        check_output("reset_ferr", longint'(FrameErr), 0);
        check_output("reset_busy", longint'(Busy), 0);
        InS   = 1'b1;
        Clear = 1'b0;
        step(6);
        check_output("idle_after_reset", longint'(Busy), 0);

        // LSB-first then MSB-first of the same line bits.
        f = '{bits: 4'b0101, rl: 1'b1, par: 1'b0, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        step(2 * CPB);
        f = '{bits: 4'b0101, rl: 1'b0, par: 1'b0, stop: 1'b1, toggle: 1'b1};
        apply_frame(f);
        step(2 * CPB);

        // Short low pulse on an idle line.
        apply_glitch();

        // Good frame, then a frame with a bad stop bit.
        f = '{bits: 4'b0101, rl: 1'b1, par: 1'b0, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        f = '{bits: 4'b1111, rl: 1'b1, par: 1'b0, stop: 1'b0, toggle: 1'b0};
        apply_frame(f);
        step(3 * CPB);
        drain();

        // Clear in the middle of a frame.
        RL = 1'b1;
        drive_bit(1'b0, 1'b0);
        drive_bit(1'b1, 1'b0);
        drive_bit(1'b0, 1'b0);
        #2 Clear = 1'b1;
        #1;
        check_output("midclear_d", longint'(D), 0);
        check_output("midclear_valid", longint'(Valid), 0);
        check_output("midclear_ferr", longint'(FrameErr), 0);
        check_output("midclear_busy", longint'(Busy), 0);
        last_good = '0;
        step(2);
        InS   = 1'b1;
        Clear = 1'b0;
        step(2 * CPB);
        check_output("idle_after_midclear", longint'(Busy), 0);

`ifdef SHFTREG_RX_PARITY_EN
        f = '{bits: 4'b0111, rl: 1'b1, par: 1'b1, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        step(CPB);
        f = '{bits: 4'b0111, rl: 1'b1, par: 1'b0, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        step(CPB);
        f = '{bits: 4'b1001, rl: 1'b0, par: 1'b0, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        f = '{bits: 4'b1101, rl: 1'b1, par: 1'b1, stop: 1'b1, toggle: 1'b0};
        apply_frame(f);
        step(CPB);
`endif

        // Randomised frames with varying gaps, orders and errors.
        for (int n = 0; n < 40; n++) begin
            f.bits   = WIDTH'($urandom);
            f.rl     = 1'($urandom_range(0, 1));
            f.stop   = ($urandom_range(0, 7) != 0);
            f.par    = (^f.bits) ^ ($urandom_range(0, 3) == 0);
            f.toggle = 1'($urandom_range(0, 1));
            apply_frame(f);
            if (!f.stop) begin
                gap = 2 * CPB + int'($urandom_range(0, 3));
            end else begin
                gap = int'($urandom_range(0, 2)) * CPB;
                if (gap > 0) gap = gap + int'($urandom_range(0, 3));
            end
            step(gap);
            if ($urandom_range(0, 5) == 0) begin
                apply_glitch();
            end
        end

        step(2 * CPB);
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
